query_patch_writer: RTL and testbench

QUERY_PATCH_WRITER -- requirements
Module: query_patch_writer

---
 rtl/query_patch_writer.sv | 107 ++++++++++
 tb/tb_query_patch_writer.sv | 371 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/query_patch_writer.sv
// query_patch_writer: gathers PATCH_SIZE streamed components into one
// packed patch and writes it to patch memory, for addresses 0..last_addr.
module query_patch_writer #(
  parameter int DATA_WIDTH = 11,
  parameter int PATCH_SIZE = 5,
  parameter int ADDR_WIDTH = 9
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             start,
  input  logic [ADDR_WIDTH-1:0]            last_addr,
  input  logic                             in_valid,
  input  logic [DATA_WIDTH-1:0]            in_data,
  output logic                             in_ready,
  output logic                             csb0,
  output logic                             web0,
  output logic [ADDR_WIDTH-1:0]            addr0,
  output logic [DATA_WIDTH*PATCH_SIZE-1:0] wpatch0,
  output logic                             busy,
  output logic                             done
);

  localparam int PW = DATA_WIDTH * PATCH_SIZE;
  localparam int CW = $clog2(PATCH_SIZE + 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FILL  = 2'd1;
  localparam logic [1:0] S_WRITE = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]            state;
  logic [ADDR_WIDTH-1:0] patch_addr;
  logic [ADDR_WIDTH-1:0] last_q;
  logic [CW-1:0]         comp_cnt;
  logic [PW-1:0]         patch;
  logic [PW-1:0]         patch_nxt;
  logic                  hs;
  logic                  last_comp;

  assign in_ready  = (state == S_FILL);
  assign busy      = (state == S_FILL) || (state == S_WRITE);
  assign done      = (state == S_DONE);
  assign hs        = in_valid && in_ready;
  assign last_comp = (comp_cnt == CW'(PATCH_SIZE - 1));

  // Patch with the incoming component dropped into its slot
  always_comb begin
    patch_nxt = patch;
    for (int k = 0; k < PATCH_SIZE; k++) begin
      if (comp_cnt == CW'(k))
        patch_nxt[k*DATA_WIDTH +: DATA_WIDTH] = in_data;
    end
  end

  // Control FSM, assembly registers and registered memory port
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      patch_addr <= '0;
      last_q     <= '0;
      comp_cnt   <= '0;
      patch      <= '0;
      csb0       <= 1'b1;
      web0       <= 1'b1;
      addr0      <= '0;
      wpatch0    <= '0;
    end else begin
      csb0 <= 1'b1;
      web0 <= 1'b1;
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            last_q     <= last_addr;
            patch_addr <= '0;
            comp_cnt   <= '0;
            state      <= S_FILL;
          end
        end
        S_FILL: begin
          if (hs) begin
            patch <= patch_nxt;
            if (last_comp) begin
              state   <= S_WRITE;
              csb0    <= 1'b0;
              web0    <= 1'b0;
              addr0   <= patch_addr;
              wpatch0 <= patch_nxt;
            end else begin
              comp_cnt <= comp_cnt + 1'b1;
            end
          end
        end
        S_WRITE: begin
          if (patch_addr == last_q) begin
            state <= S_DONE;
          end else begin
            patch_addr <= patch_addr + 1'b1;
            comp_cnt   <= '0;
            state      <= S_FILL;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_query_patch_writer.sv
// tb_query_patch_writer: directed scenarios for query_patch_writer,
// with a negedge monitor logging every memory write strobe.
module tb_query_patch_writer;

  localparam int DW = 11;
  localparam int PS = 5;
  localparam int AW = 9;
  localparam int PW = DW * PS;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [AW-1:0] last_addr = '0;
  logic          in_valid = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic          in_ready;
  logic          csb0;
  logic          web0;
  logic [AW-1:0] addr0;
  logic [PW-1:0] wpatch0;
  logic          busy;
  logic          done;

  int tests_run = 0;
  int tests_failed = 0;

  typedef struct {
    logic [AW-1:0] a;
    logic [PW-1:0] d;
    int            n;
    logic          rdy;
  } wr_t;

  wr_t wq[$];
  wr_t w;
  int  negc = 0;
  int  last_hs = -1;

  query_patch_writer #(
    .DATA_WIDTH(DW),
    .PATCH_SIZE(PS),
    .ADDR_WIDTH(AW)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .last_addr(last_addr),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready),
    .csb0     (csb0),
    .web0     (web0),
    .addr0    (addr0),
    .wpatch0  (wpatch0),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  // Log write strobes and handshake positions, away from the active edge
  always @(negedge clk) begin
    negc++;
    if (csb0 === 1'b0 && web0 === 1'b0) begin
      w.a = addr0;
      w.d = wpatch0;
      w.n = negc;
      w.rdy = in_ready;
      wq.push_back(w);
    end
    if (in_valid && in_ready) last_hs = negc;
  end

  function automatic logic [DW-1:0] cv(input int a, input int k);
    return DW'(a * 7 + k * 13 + 1);
  endfunction

  function automatic logic [PW-1:0] pack(input int a);
    logic [PW-1:0] p;
    p = '0;
    for (int k = 0; k < PS; k++) p[k*DW +: DW] = cv(a, k);
    return p;
  endfunction

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic do_start(input int la);
    start = 1'b1;
    last_addr = AW'(la);
    tick();
    start = 1'b0;
  endtask

  task automatic send(input logic [DW-1:0] d, input int gap);
    int n;
    in_valid = 1'b0;
    repeat (gap) tick();
    in_valid = 1'b1;
    in_data = d;
    n = 0;
    while (!in_ready && n < 50) begin
      tick();
      n++;
    end
    if (!in_ready) begin
      tests_run++;
      tests_failed++;
      $display("FAIL send_timeout: in_ready=%b required 1", in_ready);
    end
    tick();
    in_valid = 1'b0;
  endtask

  task automatic send_patch(input int a, input int gapmax);
    for (int k = 0; k < PS; k++)
      send(cv(a, k), gapmax > 0 ? int'($urandom_range(0, gapmax)) : 0);
  endtask

  task automatic wait_done(input int bound);
    int n;
    n = 0;
    while (!done && n < bound) begin
      tick();
      n++;
    end
    tests_run++;
    if (done !== 1'b1) begin
      tests_failed++;
      $display("FAIL done_timeout: done=%b required 1", done);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick();
    tick();
    tests_run++;
    if (busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL rst_busy: got %b want 0", busy);
    end
    tests_run++;
    if (done !== 1'b0) begin
      tests_failed++;
      $display("FAIL rst_done: got %b want 0", done);
    end
    tests_run++;
    if (in_ready !== 1'b0) begin
      tests_failed++;
      $display("FAIL rst_in_ready: got %b want 0", in_ready);
    end
    tests_run++;
    if (csb0 !== 1'b1 || web0 !== 1'b1) begin
      tests_failed++;
      $display("FAIL rst_strobe: csb0=%b web0=%b want 1 1", csb0, web0);
    end
    tests_run++;
    if (addr0 !== '0 || wpatch0 !== '0) begin
      tests_failed++;
      $display("FAIL rst_bus: addr0=%0h wpatch0=%0h want 0 0", addr0, wpatch0);
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_single();
    logic [PW-1:0] exp;
    exp = {11'd5, 11'd4, 11'd3, 11'd2, 11'd1};
    wq.delete();
    do_start(0);
    tests_run++;
    if (busy !== 1'b1 || in_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL single_fill: busy=%b in_ready=%b want 1 1", busy, in_ready);
    end
    for (int k = 1; k <= 5; k++) send(DW'(k), 0);
    wait_done(20);
    tests_run++;
    if (wq.size() != 1) begin
      tests_failed++;
      $display("FAIL single_count: got %0d want 1", wq.size());
    end else begin
      tests_run++;
      if (wq[0].a !== '0 || wq[0].d !== exp) begin
        tests_failed++;
        $display("FAIL single_write: addr=%0h data=%0h want 0 %0h",
                 wq[0].a, wq[0].d, exp);
      end
      tests_run++;
      if (wq[0].n != last_hs + 1) begin
        tests_failed++;
        $display("FAIL single_latency: strobe at %0d want %0d",
                 wq[0].n, last_hs + 1);
      end
    end
  endtask

  task automatic test_multi();
    int err;
    wq.delete();
    do_start(3);
    tests_run++;
    if (done !== 1'b0 || busy !== 1'b1) begin
      tests_failed++;
      $display("FAIL multi_restart: done=%b busy=%b want 0 1", done, busy);
    end
    for (int a = 0; a < 4; a++) send_patch(a, 0);
    wait_done(20);
    tests_run++;
    if (wq.size() != 4) begin
      tests_failed++;
      $display("FAIL multi_count: got %0d want 4", wq.size());
    end else begin
      err = 0;
      for (int i = 0; i < 4; i++)
        if (wq[i].a !== AW'(i) || wq[i].d !== pack(i)) err++;
      tests_run++;
      if (err != 0) begin
        tests_failed++;
        $display("FAIL multi_data: %0d bad writes want 0", err);
      end
      err = 0;
      for (int i = 1; i < 4; i++)
        if (wq[i].n - wq[i-1].n != PS + 1) err++;
      tests_run++;
      if (err != 0) begin
        tests_failed++;
        $display("FAIL multi_spacing: %0d bad gaps want 0", err);
      end
      err = 0;
      for (int i = 0; i < 4; i++) if (wq[i].rdy !== 1'b0) err++;
      tests_run++;
      if (err != 0) begin
        tests_failed++;
        $display("FAIL multi_ready_in_write: %0d cycles want 0", err);
      end
    end
  endtask

  task automatic test_gaps();
    int err;
    wq.delete();
    do_start(2);
    for (int a = 0; a < 3; a++) send_patch(a, 4);
    wait_done(20);
    tests_run++;
    if (wq.size() != 3) begin
      tests_failed++;
      $display("FAIL gaps_count: got %0d want 3", wq.size());
    end else begin
      err = 0;
      for (int i = 0; i < 3; i++)
        if (wq[i].a !== AW'(i) || wq[i].d !== pack(i)) err++;
      tests_run++;
      if (err != 0) begin
        tests_failed++;
        $display("FAIL gaps_data: %0d bad writes want 0", err);
      end
    end
  endtask

  task automatic test_reset_fill();
    wq.delete();
    do_start(0);
    for (int k = 0; k < 3; k++) send(cv(20, k), 0);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    tick();
    tests_run++;
    if (wq.size() != 0) begin
      tests_failed++;
      $display("FAIL rfill_nowrite: got %0d writes want 0", wq.size());
    end
    tests_run++;
    if (busy !== 1'b0 || done !== 1'b0 || in_ready !== 1'b0 ||
        csb0 !== 1'b1 || web0 !== 1'b1 ||
        addr0 !== '0 || wpatch0 !== '0) begin
      tests_failed++;
      $display("FAIL rfill_outputs: b=%b d=%b r=%b c=%b w=%b a=%0h p=%0h want 0 0 0 1 1 0 0",
               busy, done, in_ready, csb0, web0, addr0, wpatch0);
    end
    do_start(0);
    send_patch(9, 0);
    wait_done(20);
    tests_run++;
    if (wq.size() != 1 || wq[0].a !== '0 || wq[0].d !== pack(9)) begin
      tests_failed++;
      $display("FAIL rfill_clean: n=%0d addr=%0h data=%0h want 1 0 %0h",
               wq.size(), wq.size() > 0 ? wq[0].a : '0,
               wq.size() > 0 ? wq[0].d : '0, pack(9));
    end
  endtask

  task automatic test_start_ignored();
    wq.delete();
    do_start(1);
    send(cv(0, 0), 0);
    send(cv(0, 1), 0);
    start = 1'b1;
    last_addr = AW'(5);
    send(cv(0, 2), 0);
    start = 1'b0;
    send(cv(0, 3), 0);
    send(cv(0, 4), 0);
    send_patch(1, 0);
    wait_done(20);
    repeat (20) tick();
    tests_run++;
    if (wq.size() != 2) begin
      tests_failed++;
      $display("FAIL ign_count: got %0d want 2", wq.size());
    end else begin
      tests_run++;
      if (wq[0].d !== pack(0) || wq[1].a !== AW'(1) || wq[1].d !== pack(1)) begin
        tests_failed++;
        $display("FAIL ign_data: a1=%0h d0=%0h want 1 %0h", wq[1].a, wq[0].d, pack(0));
      end
    end
    tests_run++;
    if (done !== 1'b1) begin
      tests_failed++;
      $display("FAIL ign_done: got %b want 1", done);
    end
  endtask

  task automatic test_full_range();
    int err;
    wq.delete();
    do_start(511);
    for (int a = 0; a < 512; a++) send_patch(a, 0);
    wait_done(20);
    repeat (10) tick();
    tests_run++;
    if (wq.size() != 512) begin
      tests_failed++;
      $display("FAIL full_count: got %0d want 512", wq.size());
    end else begin
      err = 0;
      for (int i = 0; i < 512; i++)
        if (wq[i].a !== AW'(i) || wq[i].d !== pack(i)) err++;
      tests_run++;
      if (err != 0) begin
        tests_failed++;
        $display("FAIL full_data: %0d bad writes want 0", err);
      end
      tests_run++;
      if (wq[511].a !== 9'd511 || addr0 !== 9'd511) begin
        tests_failed++;
        $display("FAIL full_last: got %0h/%0h want 1ff", wq[511].a, addr0);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_multi();
    test_gaps();
    test_reset_fill();
    test_start_ignored();
    test_full_range();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
